// File: rtl/rr_hold_arbiter.sv
// ---------------------------------------------------------------------------
// rr_hold_arbiter
//   N-requester round-robin arbiter with a bounded grant tenure. Sits between
//   N bus masters and one shared slave port. All outputs are registered.
//
//   A tenure lasts while the owner keeps requesting, up to MAX_HOLD cycles.
//   At that limit the grant passes to the next active requester in
//   round-robin order, and preempt pulses. If nobody else is waiting, the
//   owner is re-granted with a fresh tenure and no idle cycle in between.
//
//   Optional feature (macro ARB_LOCK_EN): adds a 'lock' input. While the
//   owner is requesting with lock=1, its tenure may run past MAX_HOLD.
//   hold_cnt saturates at MAX_HOLD in that case.
//
// Parameters
//   N         number of requesters (2..16)
//   MAX_HOLD  maximum consecutive grant cycles per tenure (1..255)
//   IDW       width of gnt_id
//   CW        width of hold_cnt
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   lock       (ARB_LOCK_EN only) owner extends its tenure past MAX_HOLD
//   req        level-sensitive request vector, bit k = requester k
//   gnt        one-hot grant, all zero when idle
//   gnt_id     index of current owner (0 when idle)
//   gnt_valid  high when any gnt bit is high
//   hold_cnt   cycles granted in current tenure, 1 on first grant cycle
//   preempt    one-cycle pulse when the owner loses grant while requesting
// ---------------------------------------------------------------------------
module rr_hold_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    parameter int IDW      = $clog2(N),
    parameter int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic           clk,
    input  logic           reset,
`ifdef ARB_LOCK_EN
    input  logic           lock,
`endif
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic [CW-1:0]  hold_cnt,
    output logic           preempt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state_q,     state_d;
    logic [IDW-1:0] ptr_q,       ptr_d;
    logic [N-1:0]   gnt_q,       gnt_d;
    logic [IDW-1:0] gnt_id_q,    gnt_id_d;
    logic           gnt_valid_q, gnt_valid_d;
    logic [CW-1:0]  hold_cnt_q,  hold_cnt_d;
    logic           preempt_q,   preempt_d;

    logic           own_req;
    logic           lock_hold;
    logic           at_limit;
    logic [IDW:0]   srch;
    logic           take;
    logic [IDW-1:0] take_id;
    logic           extend;
    logic           go_idle;

    // Round-robin search: scan start+1, start+2, ... wrapping modulo N and
    // return {found, index} of the first active requester. With skip_start
    // set, the start position itself (visited last) is excluded, which is
    // how "any other requester" is found at tenure expiry.
    function automatic logic [IDW:0] rr_search(
        input logic [N-1:0]   r,
        input logic [IDW-1:0] start,
        input logic           skip_start
    );
        logic           found;
        logic [IDW-1:0] win;
        int             idx;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(start) + k;
            if (idx >= N) idx = idx - N;
            if (!found && r[IDW'(idx)] && !(skip_start && (k == N))) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
        return {found, win};
    endfunction

`ifdef ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    assign own_req  = req[gnt_id_q];
    assign at_limit = (hold_cnt_q >= CW'(MAX_HOLD));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        hold_cnt_d  = hold_cnt_q;
        preempt_d   = 1'b0;
        srch        = '0;
        take        = 1'b0;
        take_id     = '0;
        extend      = 1'b0;
        go_idle     = 1'b0;

        case (state_q)
            IDLE: begin
                srch    = rr_search(req, ptr_q, 1'b0);
                take    = srch[IDW];
                take_id = srch[IDW-1:0];
            end
            GRANT: begin
                if (own_req && (!at_limit || lock_hold)) begin
                    extend = 1'b1;
                end else if (own_req) begin
                    // Tenure expired while still requesting: hand over if
                    // anyone else waits, otherwise restart the owner's tenure.
                    srch = rr_search(req, gnt_id_q, 1'b1);
                    take = 1'b1;
                    if (srch[IDW]) begin
                        take_id   = srch[IDW-1:0];
                        preempt_d = 1'b1;
                    end else begin
                        take_id   = gnt_id_q;
                    end
                end else begin
                    // Owner released; the owner's own bit is 0, so a full
                    // scan naturally leaves it lowest priority.
                    srch    = rr_search(req, gnt_id_q, 1'b0);
                    take    = srch[IDW];
                    take_id = srch[IDW-1:0];
                    go_idle = !srch[IDW];
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (take) begin
            state_d     = GRANT;
            ptr_d       = take_id;
            gnt_d       = {{(N-1){1'b0}}, 1'b1} << take_id;
            gnt_id_d    = take_id;
            gnt_valid_d = 1'b1;
            hold_cnt_d  = CW'(1);
        end else if (extend) begin
            // Saturate rather than wrap when lock holds past the limit.
            if (!at_limit) hold_cnt_d = hold_cnt_q + CW'(1);
        end else if (go_idle) begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_id_d    = '0;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = '0;
        end
    end

    // Reset points ptr at N-1 so requester 0 is searched first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= IDW'(N - 1);
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            hold_cnt_q  <= '0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            hold_cnt_q  <= hold_cnt_d;
            preempt_q   <= preempt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign hold_cnt  = hold_cnt_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_hold_arbiter
//   Directed bench for rr_hold_arbiter. One instance with N=4, MAX_HOLD=16
//   and one with N=8, MAX_HOLD=1. The lock sequence is built only when
//   ARB_LOCK_EN is defined.
// ---------------------------------------------------------------------------
module tb_rr_hold_arbiter;

    logic       clk;
    logic       reset;
    logic       lock;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic [4:0] hold_cnt;
    logic       preempt;

    logic       reset8;
    logic       lock8;
    logic [7:0] req8;
    logic [7:0] gnt8;
    logic [2:0] gnt_id8;
    logic       gnt_valid8;
    logic [0:0] hold_cnt8;
    logic       preempt8;

    int checks = 0;
    int errors = 0;

    rr_hold_arbiter #(.N(4), .MAX_HOLD(16)) u_dut (
        .clk       (clk),
        .reset     (reset),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .hold_cnt  (hold_cnt),
        .preempt   (preempt)
    );

    rr_hold_arbiter #(.N(8), .MAX_HOLD(1)) u_dut8 (
        .clk       (clk),
        .reset     (reset8),
`ifdef ARB_LOCK_EN
        .lock      (lock8),
`endif
        .req       (req8),
        .gnt       (gnt8),
        .gnt_id    (gnt_id8),
        .gnt_valid (gnt_valid8),
        .hold_cnt  (hold_cnt8),
        .preempt   (preempt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       vld;
        logic [4:0] hold;
        logic       pre;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic reset4();
        reset = 1'b0;
        req   = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset  = 1'b0;
        reset8 = 1'b0;
        lock   = 1'b0;
        lock8  = 1'b0;
        req    = 4'b1111;
        req8   = 8'h00;

        // Vector table, applied right after a reset (ptr = 3).
        tbl[0]  = '{4'b1001, 4'b0001, 2'd0, 1'b1, 5'd1, 1'b0};
        tbl[1]  = '{4'b1001, 4'b0001, 2'd0, 1'b1, 5'd2, 1'b0};
        tbl[2]  = '{4'b1001, 4'b0001, 2'd0, 1'b1, 5'd3, 1'b0};
        tbl[3]  = '{4'b1001, 4'b0001, 2'd0, 1'b1, 5'd4, 1'b0};
        tbl[4]  = '{4'b1001, 4'b0001, 2'd0, 1'b1, 5'd5, 1'b0};
        tbl[5]  = '{4'b1000, 4'b1000, 2'd3, 1'b1, 5'd1, 1'b0};
        tbl[6]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 5'd0, 1'b0};
        tbl[7]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 5'd0, 1'b0};
        tbl[8]  = '{4'b0110, 4'b0010, 2'd1, 1'b1, 5'd1, 1'b0};
        tbl[9]  = '{4'b0111, 4'b0010, 2'd1, 1'b1, 5'd2, 1'b0};
        tbl[10] = '{4'b0101, 4'b0100, 2'd2, 1'b1, 5'd1, 1'b0};
        tbl[11] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 5'd1, 1'b0};
        tbl[12] = '{4'b1000, 4'b1000, 2'd3, 1'b1, 5'd1, 1'b0};
        tbl[13] = '{4'b0100, 4'b0100, 2'd2, 1'b1, 5'd1, 1'b0};
        tbl[14] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 5'd0, 1'b0};
        tbl[15] = '{4'b0010, 4'b0010, 2'd1, 1'b1, 5'd1, 1'b0};

        // Reset state with all requesting, then first grant after release.
        repeat (3) @(posedge clk);
        #1;
        chk("rst gnt",       32'(gnt),       32'h0);
        chk("rst gnt_id",    32'(gnt_id),    32'h0);
        chk("rst gnt_valid", 32'(gnt_valid), 32'h0);
        chk("rst hold_cnt",  32'(hold_cnt),  32'h0);
        chk("rst preempt",   32'(preempt),   32'h0);
        reset = 1'b1;
        step(4'b1111);
        chk("first gnt",      32'(gnt),       32'h1);
        chk("first gnt_id",   32'(gnt_id),    32'h0);
        chk("first valid",    32'(gnt_valid), 32'h1);
        chk("first hold_cnt", 32'(hold_cnt),  32'h1);

        // Preemption at MAX_HOLD between requesters 0 and 1.
        reset4();
        for (int i = 1; i <= 16; i++) begin
            step(4'b0011);
            chk($sformatf("pre0 gnt c%0d", i),  32'(gnt),      32'h1);
            chk($sformatf("pre0 hold c%0d", i), 32'(hold_cnt), 32'(i));
            chk($sformatf("pre0 pre c%0d", i),  32'(preempt),  32'h0);
        end
        step(4'b0011);
        chk("pre hand1 gnt",  32'(gnt),      32'h2);
        chk("pre hand1 hold", 32'(hold_cnt), 32'h1);
        chk("pre hand1 pre",  32'(preempt),  32'h1);
        for (int i = 2; i <= 16; i++) begin
            step(4'b0011);
            chk($sformatf("pre1 gnt c%0d", i),  32'(gnt),      32'h2);
            chk($sformatf("pre1 hold c%0d", i), 32'(hold_cnt), 32'(i));
            chk($sformatf("pre1 pre c%0d", i),  32'(preempt),  32'h0);
        end
        step(4'b0011);
        chk("pre hand0 gnt",  32'(gnt),      32'h1);
        chk("pre hand0 hold", 32'(hold_cnt), 32'h1);
        chk("pre hand0 pre",  32'(preempt),  32'h1);

        // Sole requester: tenure restarts with no bubble and no preempt.
        reset4();
        for (int i = 1; i <= 40; i++) begin
            step(4'b0100);
            chk($sformatf("sole gnt c%0d", i),  32'(gnt),      32'h4);
            chk($sformatf("sole hold c%0d", i), 32'(hold_cnt), 32'(((i - 1) % 16) + 1));
            chk($sformatf("sole pre c%0d", i),  32'(preempt),  32'h0);
        end

        // Owner drops req on the same edge its tenure hits the limit:
        // a plain release, not a preemption.
        reset4();
        for (int i = 1; i <= 16; i++) step(4'b0011);
        chk("simul hold16", 32'(hold_cnt), 32'd16);
        step(4'b0010);
        chk("simul gnt",  32'(gnt),      32'h2);
        chk("simul hold", 32'(hold_cnt), 32'h1);
        chk("simul pre",  32'(preempt),  32'h0);

        // Table-driven: early release, idle return, mid-tenure arrivals,
        // handover order and skipped requesters.
        reset4();
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].req);
            chk($sformatf("vec%0d gnt", i),   32'(gnt),       32'(tbl[i].gnt));
            chk($sformatf("vec%0d id", i),    32'(gnt_id),    32'(tbl[i].id));
            chk($sformatf("vec%0d valid", i), 32'(gnt_valid), 32'(tbl[i].vld));
            chk($sformatf("vec%0d hold", i),  32'(hold_cnt),  32'(tbl[i].hold));
            chk($sformatf("vec%0d pre", i),   32'(preempt),   32'(tbl[i].pre));
        end

`ifdef ARB_LOCK_EN
        // Lock extends the tenure past MAX_HOLD; releasing it preempts.
        reset4();
        lock = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step(4'b0011);
            chk($sformatf("lock gnt c%0d", i),  32'(gnt),      32'h1);
            chk($sformatf("lock hold c%0d", i), 32'(hold_cnt), 32'((i > 16) ? 16 : i));
            chk($sformatf("lock pre c%0d", i),  32'(preempt),  32'h0);
        end
        lock = 1'b0;
        step(4'b0011);
        chk("unlock gnt",  32'(gnt),      32'h2);
        chk("unlock hold", 32'(hold_cnt), 32'h1);
        chk("unlock pre",  32'(preempt),  32'h1);
`endif

        // Fairness on the 8-way, MAX_HOLD=1 instance.
        reset8 = 1'b1;
        req8   = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("fair gnt c%0d", i),  32'(gnt8),      32'(1 << (i % 8)));
            chk($sformatf("fair id c%0d", i),   32'(gnt_id8),   32'(i % 8));
            chk($sformatf("fair hold c%0d", i), 32'(hold_cnt8), 32'h1);
            chk($sformatf("fair pre c%0d", i),  32'(preempt8),  32'((i != 0) ? 1 : 0));
        end
        // Asynchronous reset mid-cycle clears grant before the next edge.
        reset8 = 1'b0;
        #2;
        chk("async gnt",   32'(gnt8),       32'h0);
        chk("async valid", 32'(gnt_valid8), 32'h0);
        chk("async hold",  32'(hold_cnt8),  32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_hold_arbiter.md
Name: rr_hold_arbiter

Overview:
N-requester round-robin arbiter with a bounded grant tenure. It is the parametrised successor of the team's fixed 4-way arbiter, generalised in requester count and maximum hold length. Outputs are registered, with a one-hot grant, an encoded owner index and a tenure counter. It sits between N bus masters and a single shared slave port.

Parameters:
N, 4, number of requesters; legal range 2..16.
MAX_HOLD, 16, maximum consecutive grant cycles per tenure; legal range 1..255.
IDW, $clog2(N), width of gnt_id.
CW, $clog2(MAX_HOLD+1), width of hold_cnt.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous active-low reset.
req  input  N  request vector; bit k is requester k, level-sensitive.
gnt  output  N  registered one-hot grant; all zero when idle.
gnt_id  output  IDW  index of the current owner; valid only while gnt_valid=1.
gnt_valid  output  1  high when any gnt bit is high.
hold_cnt  output  CW  cycles granted in the current tenure; 1 on the first grant cycle.
preempt  output  1  one-cycle pulse on the cycle the owner loses grant while still requesting.

Behaviour:
- Reset is asynchronous on reset=0. Outputs clear: gnt=0, gnt_id=0, gnt_valid=0, hold_cnt=0, preempt=0.
- Reset sets the round-robin pointer ptr=N-1, so requester 0 has top priority after reset.
- Reset mid-tenure drops grant immediately; there is no completion of the tenure.
- State machine has two states, IDLE and GRANT. All outputs are flops updated on the rising clock edge.
- Search order: candidates are scanned ptr+1, ptr+2, ... wrapping modulo N; the first requester with req=1 wins.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise: go to GRANT next edge, grant the winner, hold_cnt=1, ptr=winner.
  - Latency is exactly 1 cycle from req sampled high to gnt high.
- GRANT, owner o, evaluated each edge:
  - (a) req[o]=1 and hold_cnt<MAX_HOLD: keep o and increment hold_cnt.
  - (b) req[o]=0: search from o+1. If a winner w exists, grant w with hold_cnt=1 and no idle bubble. If req==0, go to IDLE with gnt=0 and hold_cnt=0.
  - (c) req[o]=1 and hold_cnt==MAX_HOLD:
    - If any other requester is active, grant the next one in search order, set hold_cnt=1, and pulse preempt=1 for one cycle.
    - If o is the only requester, re-grant o with hold_cnt=1 and preempt=0; tenure restarts with no bubble.
- ptr always equals the current or last owner, so the departing owner is lowest priority on handover.
- Exactly one gnt bit is high in GRANT, and gnt_id matches it. hold_cnt never exceeds MAX_HOLD and never wraps.
- Simultaneous events: the owner dropping req on the same edge hold_cnt hits MAX_HOLD is case (b), so there is no preempt pulse. New requests arriving mid-tenure have no effect until handover.
- MAX_HOLD=1 degenerates to strict per-cycle round-robin among active requesters.
- Requests are not latched. A requester that drops req before being granted is skipped.

Optional Feature:
Macro ARB_LOCK_EN.
- Defined: adds input port lock (1 bit).
  - While the owner holds lock=1 with req[o]=1, case (c) is suppressed and the tenure continues past MAX_HOLD.
  - hold_cnt saturates at MAX_HOLD; preempt stays 0.
  - lock is ignored in IDLE and when req[o]=0.
  - Deasserting lock with hold_cnt==MAX_HOLD applies case (c) on the next edge.
- Undefined: no lock port, and tenure is always bounded by MAX_HOLD.

Test Plan:
1. Reset state (N=4, MAX_HOLD=16): reset=0 with req=4'b1111, then release → all outputs 0 during reset; first edge after release gives gnt=4'b0001, gnt_id=0, hold_cnt=1.
2. Preemption and saturation: req=4'b0011 held constant → gnt=0001 for 16 cycles (hold_cnt 1..16), then gnt=0010 with preempt=1 for one cycle. Next, gnt=0010 for 16 cycles, then back to 0001.
3. Sole requester: req=4'b0100 held for 40 cycles → gnt=0100 throughout with no gap; hold_cnt runs 1..16, 1..16, 1..8; preempt never asserts.
4. Early release and idle return: owner 0 drops req at hold_cnt=5 while req[3]=1 → next edge gnt=1000, hold_cnt=1. Then req=0 → next edge gnt=0, gnt_valid=0, state IDLE.
5. Fairness: N=8, MAX_HOLD=1, req=8'hFF → gnt cycles 0,1,...,7,0, one per cycle. An async reset asserted mid-sequence clears gnt within the same cycle.
6. Lock extension (ARB_LOCK_EN defined): lock=1, req=4'b0011 → gnt=0001 for 30 cycles with hold_cnt stuck at 16. Drop lock → next edge gnt=0010 with preempt=1.
